// File: rtl/bcd_display_scan_pkg.sv
// Shared types and 7-segment pattern constants for the BCD display scanner.
// Patterns are active-high, {g,f,e,d,c,b,a} with segment a in bit 0.
package bcd_display_scan_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_pat_t;

  localparam seg_pat_t SEG_0    = 7'h3F;
  localparam seg_pat_t SEG_1    = 7'h06;
  localparam seg_pat_t SEG_2    = 7'h5B;
  localparam seg_pat_t SEG_3    = 7'h4F;
  localparam seg_pat_t SEG_4    = 7'h66;
  localparam seg_pat_t SEG_5    = 7'h6D;
  localparam seg_pat_t SEG_6    = 7'h7D;
  localparam seg_pat_t SEG_7    = 7'h07;
  localparam seg_pat_t SEG_8    = 7'h7F;
  localparam seg_pat_t SEG_9    = 7'h6F;
  localparam seg_pat_t SEG_DASH = 7'h40;
  localparam seg_pat_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Digit-word input and display-pin bundle of the BCD display scanner.
// The slave side is the scanner; the master side feeds digits and watches the pins.
interface bcd_display_scan_if #(
  parameter int unsigned DIGITS = 4
) ();

  logic                  load;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     dig_sel;
  logic                  frame_done;

  modport master (
    output load, bcd_in, dp_in, blank_lz,
    input  seg, dp, dig_sel, frame_done
  );

  modport slave (
    input  load, bcd_in, dp_in, blank_lz,
    output seg, dp, dig_sel, frame_done
  );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
  import bcd_display_scan_pkg::*;
(
  input  bcd_digit_t code,
  output seg_pat_t   pattern
);

  always_comb begin
    pattern = SEG_DASH;
    unique case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed 7-segment scanner with double-buffered digits, dead time between
// slots and optional leading-zero blanking. All pins are registered.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 1000,
  parameter int unsigned DEAD           = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input logic              clk,
  input logic              rst,
  bcd_display_scan_if.slave bus
);

  localparam int unsigned CntW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IdxW    = $clog2(DIGITS);
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
  localparam seg_pat_t          SegInact = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DigInact = {DIGITS{DIG_ACTIVE_LOW}};

  logic [DIGITS-1:0][3:0] pend_bcd_q, act_bcd_q;
  logic [DIGITS-1:0]      pend_dp_q, act_dp_q;
  logic                   pend_valid_q;
  logic [CntW-1:0]        cnt_q;
  logic [IdxW-1:0]        idx_q;

  seg_pat_t               seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [DIGITS-1:0]      dig_q, dig_d;
  logic                   frame_done_q;

  logic                   slot_end, frame_end, drive_en, blank;
  logic [DIGITS:0]        zero_run;
  logic [DIGITS-1:0]      onehot;
  bcd_digit_t             cur_code;
  seg_pat_t               cur_pat;

  bcd_to_seg u_dec (
    .code    (cur_code),
    .pattern (cur_pat)
  );

  always_comb begin
    slot_end  = (cnt_q == CntLast);
    frame_end = slot_end && (idx_q == IdxLast);
    drive_en  = int'(cnt_q) >= int'(DEAD);
    cur_code  = act_bcd_q[idx_q];
    onehot    = DIGITS'(1) << idx_q;

    // zero_run[i]: active digits i..DIGITS-1 are all zero
    zero_run[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run[i] = zero_run[i+1] & (act_bcd_q[i] == 4'd0);
    end
    blank = bus.blank_lz && (idx_q != '0) && zero_run[idx_q];

    seg_d = SegInact;
    dp_d  = SEG_ACTIVE_LOW;
    dig_d = DigInact;
    if (drive_en) begin
      seg_d = (blank ? SEG_OFF : cur_pat) ^ {7{SEG_ACTIVE_LOW}};
      dp_d  = act_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
      dig_d = onehot ^ {DIGITS{DIG_ACTIVE_LOW}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      act_bcd_q    <= '0;
      act_dp_q     <= '0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= SegInact;
      dp_q         <= SEG_ACTIVE_LOW;
      dig_q        <= DigInact;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q <= slot_end ? '0 : cnt_q + CntW'(1);
      if (slot_end) begin
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      end

      if (frame_end && pend_valid_q) begin
        act_bcd_q <= pend_bcd_q;
        act_dp_q  <= pend_dp_q;
      end

      // A load on the boundary edge stays pending for the next frame
      if (bus.load) begin
        pend_bcd_q   <= bus.bcd_in;
        pend_dp_q    <= bus.dp_in;
        pend_valid_q <= 1'b1;
      end else if (frame_end) begin
        pend_valid_q <= 1'b0;
      end

      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_end;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_done = frame_done_q;

endmodule
